// File: rtl/bram_readout_pkg.sv
// Shared types and constants for the BRAM readout sweep engine.
package bram_readout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  // A new read may be issued only if every word already owed to the FIFO
  // (stored, minus the one leaving this cycle, plus the one in flight) still
  // leaves a free slot for it.
  function automatic logic room_ok(input logic [CNT_W-1:0] occ,
                                   input logic             pop,
                                   input logic             inflight);
    return (int'(occ) - int'(pop) + int'(inflight)) < FIFO_DEPTH;
  endfunction

endpackage

// File: rtl/bram_readout_if.sv
// Ready/valid output stream of the BRAM readout engine.
interface bram_readout_if #(
  parameter int datBit   = 17,
  parameter int addrBit  = 9,
  parameter int totUnits = 31
);
  localparam int unitW = $clog2(totUnits + 1);

  logic [datBit:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic [unitW-1:0] out_unit;
  logic [addrBit:0] out_addr;
  logic             out_last;

  modport master (
    output out_data, out_valid, out_unit, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_unit, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/bram_readout_fifo2.sv
// Two-entry output FIFO; the head entry is held stable until it is popped.
module readout_fifo2
  import bram_readout_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     slot0_q;
  logic [W-1:0]     slot1_q;
  logic [CNT_W-1:0] cnt_q;

  // Slot 0 is always the head; slot 1 shifts forward on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) slot0_q <= din;
          else             slot1_q <= din;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        2'b01: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        2'b11: begin
          if (cnt_q == CNT_W'(1)) begin
            slot0_q <= din;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0_q;
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/bram_readout.sv
// Sweeps every word of a bank array (address-major, unit-minor) and streams
// it out over a ready/valid interface through a 2-entry FIFO.
// Optional feature: define CLEAR_ON_READ_EN to zero each word as it is read.
module bram_readout
  import bram_readout_pkg::*;
#(
  parameter int datBit   = 17,
  parameter int addrBit  = 9,
  parameter int totUnits = 31
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         start,
  output logic [addrBit:0]             ra,
  input  logic [totUnits:0][datBit:0]  rd,
  bram_readout_if.master               ob,
  output logic                         busy,
  output logic                         done,
  output logic [totUnits:0]            we,
  output logic [addrBit:0]             wa,
  output logic [datBit:0]              wd
);

  localparam int unitW = $clog2(totUnits + 1);
  localparam int entW  = 1 + unitW + (addrBit + 1) + (datBit + 1);

  state_t           state_q;
  logic [addrBit:0] addr_p0;
  logic [unitW-1:0] unit_p0;
  logic             vld_p1;
  logic             last_p1;
  logic [addrBit:0] addr_p1;
  logic [unitW-1:0] unit_p1;
  logic             issue;
  logic             last_issue;
  logic             pop;
  logic [CNT_W-1:0] occ;
  logic             fifo_valid;
  logic [entW-1:0]  fifo_din;
  logic [entW-1:0]  fifo_dout;

  assign pop        = fifo_valid & ob.out_ready;
  assign last_issue = (&addr_p0) && (unit_p0 == unitW'(totUnits));

  // Read issue: the start cycle itself issues word 0, then flow-controlled.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      IDLE:    issue = start;
      SWEEP:   issue = room_ok(occ, pop, vld_p1);
      default: issue = 1'b0;
    endcase
  end

  // ---- stage p0: FSM and issue counters (ra is the next read address) ----
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      addr_p0 <= '0;
      unit_p0 <= '0;
    end else begin
      if (issue) begin
        if (unit_p0 == unitW'(totUnits)) begin
          unit_p0 <= '0;
          addr_p0 <= addr_p0 + 1'b1;
        end else begin
          unit_p0 <= unit_p0 + 1'b1;
        end
      end
      case (state_q)
        IDLE:    if (start) state_q <= SWEEP;
        SWEEP:   if (issue && last_issue) state_q <= DRAIN;
        DRAIN:   if (pop && ob.out_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- stage p1: read in flight, bank data arrives this cycle ----
  always_ff @(posedge clk) begin
    if (RST) vld_p1 <= 1'b0;
    else     vld_p1 <= issue;
  end

  // Tag of the in-flight read; only meaningful while vld_p1 is high.
  always_ff @(posedge clk) begin
    if (issue) begin
      addr_p1 <= addr_p0;
      unit_p1 <= unit_p0;
      last_p1 <= last_issue;
    end
  end

  assign ra       = addr_p0;
  assign fifo_din = {last_p1, unit_p1, addr_p1, rd[unit_p1]};

  readout_fifo2 #(.W(entW)) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (vld_p1),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (occ)
  );

  assign {ob.out_last, ob.out_unit, ob.out_addr, ob.out_data} = fifo_dout;
  assign ob.out_valid = fifo_valid;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DRAIN) && pop && ob.out_last;

`ifdef CLEAR_ON_READ_EN
  // Write zero back to the word being captured so the bank ends up cleared.
  always_comb begin
    we = '0;
    wa = '0;
    wd = '0;
    if (vld_p1) begin
      we[unit_p1] = 1'b1;
      wa          = addr_p1;
    end
  end
`else
  assign we = '0;
  assign wa = '0;
  assign wd = '0;
`endif

endmodule

// File: tb/tb_bram_readout.sv
// Directed bench for bram_readout with a behavioural bank array model.
module tb_bram_readout;

  localparam int DB = 17;
  localparam int AB = 2;
  localparam int TU = 3;
  localparam int NA = 2 ** (AB + 1);
  localparam int NW = (TU + 1) * NA;

  logic                clk = 1'b0;
  logic                RST = 1'b1;
  logic                start = 1'b0;
  logic [AB:0]         ra;
  logic [TU:0][DB:0]   rd;
  logic                busy;
  logic                done;
  logic [TU:0]         we;
  logic [AB:0]         wa;
  logic [DB:0]         wd;

  bram_readout_if #(.datBit(DB), .addrBit(AB), .totUnits(TU)) ob ();

  bram_readout #(.datBit(DB), .addrBit(AB), .totUnits(TU)) dut (
    .clk   (clk),
    .RST   (RST),
    .start (start),
    .ra    (ra),
    .rd    (rd),
    .ob    (ob),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always #5 clk = ~clk;

  logic [DB:0] mem [TU+1][NA];
  bit          preload_req = 1'b0;

  always @(posedge clk) begin
    for (int u = 0; u <= TU; u++) begin
      rd[u] <= mem[u][ra];
      if (preload_req) begin
        for (int a = 0; a < NA; a++) mem[u][a] <= 18'(16 * u + a);
      end else if (we[u]) begin
        mem[u][wa] <= wd;
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  function automatic logic [DB:0] expv(input int n, input bit zeros);
    return zeros ? '0 : 18'(16 * (n % (TU + 1)) + n / (TU + 1));
  endfunction

  task automatic sweep(input string nm, input bit toggle, input int restart_at,
                       input int rst_at, input bit zeros);
    int          n, cyc, first_cyc, last_cyc, caps;
    bit          held, restarted, we_bad;
    logic [DB:0] hd;
    logic [AB:0] ha;
    logic [1:0]  hu;
    logic        hl;
    n = 0; cyc = 0; first_cyc = -1; last_cyc = -1; caps = 0;
    held = 0; restarted = 0; we_bad = 0;
    hd = '0; ha = '0; hu = '0; hl = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ob.out_ready = 1'b1;
    #1;
    chk({nm, "_valid_at_start"}, ob.out_valid, 0);
    while (n < NW && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ob.out_ready = toggle ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      if (restart_at >= 0 && n == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (rst_at >= 0 && n == rst_at) begin
        RST = 1'b1;
        ob.out_ready = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk({nm, "_rst_valid"}, ob.out_valid, 0);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_ra"}, ra, 0);
        chk({nm, "_rst_data"}, ob.out_data, 0);
        chk({nm, "_rst_addr"}, ob.out_addr, 0);
        chk({nm, "_rst_unit"}, ob.out_unit, 0);
        chk({nm, "_rst_we"}, we, 0);
        return;
      end
      #1;
`ifdef CLEAR_ON_READ_EN
      if (we != '0) begin
        chk({nm, "_we_onehot"}, we, 64'(1) << (caps % (TU + 1)));
        chk({nm, "_wa"}, wa, caps / (TU + 1));
        chk({nm, "_wd"}, wd, 0);
        caps++;
      end
`else
      if (we != '0 || wa != '0 || wd != '0) we_bad = 1;
`endif
      if (held) begin
        chk({nm, "_stall_valid"}, ob.out_valid, 1);
        chk({nm, "_stall_data"}, ob.out_data, hd);
        chk({nm, "_stall_addr"}, ob.out_addr, ha);
        chk({nm, "_stall_unit"}, ob.out_unit, hu);
        chk({nm, "_stall_last"}, ob.out_last, hl);
      end
      if (ob.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (ob.out_ready) begin
          chk({nm, "_data"}, ob.out_data, expv(n, zeros));
          chk({nm, "_addr"}, ob.out_addr, n / (TU + 1));
          chk({nm, "_unit"}, ob.out_unit, n % (TU + 1));
          chk({nm, "_last"}, ob.out_last, (n == NW - 1));
          chk({nm, "_done"}, done, (n == NW - 1));
          last_cyc = cyc;
          n++;
          held = 0;
        end else begin
          held = 1;
          hd = ob.out_data; ha = ob.out_addr; hu = ob.out_unit; hl = ob.out_last;
        end
      end else begin
        held = 0;
      end
    end
    chk({nm, "_word_count"}, n, NW);
    if (!toggle) begin
      chk({nm, "_first_latency"}, first_cyc, 2);
      chk({nm, "_back_to_back"}, last_cyc - first_cyc + 1, NW);
    end
`ifdef CLEAR_ON_READ_EN
    chk({nm, "_clear_writes"}, caps, NW);
`else
    chk({nm, "_we_tied"}, we_bad, 0);
`endif
    repeat (4) @(negedge clk);
    #1;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_valid"}, ob.out_valid, 0);
  endtask

  initial begin
    ob.out_ready = 1'b0;
    RST = 1'b1;
    preload();
    @(negedge clk);
    #1;
    chk("reset_valid", ob.out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ra", ra, 0);
    chk("reset_we", we, 0);
    chk("reset_data", ob.out_data, 0);
    chk("reset_last", ob.out_last, 0);
    RST = 1'b0;

    sweep("full", 0, -1, -1, 0);
    preload();
    sweep("stall", 1, -1, -1, 0);
    preload();
    sweep("restart", 0, 10, -1, 0);
    preload();
    sweep("midrst", 0, -1, 12, 0);
    preload();
    sweep("after_rst", 0, -1, -1, 0);
    preload();
    sweep("first", 0, -1, -1, 0);
`ifdef CLEAR_ON_READ_EN
    sweep("cleared", 0, -1, -1, 1);
`else
    sweep("kept", 0, -1, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
